signed_adder_arbiter: RTL

SIGNED_ADDER_ARBITER -- requirements
Module: signed_adder_arbiter

---
 rtl/signed_adder_arbiter_pkg.sv | 30 +++
 rtl/signed_adder_arbiter_rr.sv | 38 +++
 rtl/signed_adder_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/signed_adder_arbiter_pkg.sv
// Shared widths, operand/sum types and control-FSM states for signed_adder_arbiter.
// The sum is one bit wider than the operands so every 4-bit signed pair adds exactly.
package signed_adder_arbiter_pkg;

    localparam int OPND_W = 4;
    localparam int SUM_W  = 5;

    typedef logic signed [OPND_W-1:0] opnd_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Both operands are sign-extended before the add, so the result never wraps.
    function automatic sum_t add_sext(input opnd_t a, input opnd_t b);
        sum_t a_ext;
        sum_t b_ext;
        a_ext = {a[OPND_W-1], a};
        b_ext = {b[OPND_W-1], b};
        return a_ext + b_ext;
    endfunction

    // The sum leaves the 4-bit range exactly when its top two bits disagree.
    function automatic logic sum_ovf(input sum_t s);
        return s[SUM_W-1] ^ s[SUM_W-2];
    endfunction

endpackage

// File: rtl/signed_adder_arbiter_rr.sv
// Round-robin grant logic: scans from ptr_i upward, wrapping at NUM_REQ-1, and
// grants the first requester with its request bit set. Output is one-hot or zero.
module rr_arbiter
    import signed_adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // One spare bit so ptr + offset can be compared against NUM_REQ before wrapping.
    typedef logic [ID_W:0] idx_t;

    idx_t idx;
    logic found;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = idx_t'(ptr_i) + idx_t'(k);
            if (idx >= idx_t'(NUM_REQ)) begin
                idx = idx - idx_t'(NUM_REQ);
            end
            if (enable_i && !found && req_i[idx[ID_W-1:0]]) begin
                grant_o[idx[ID_W-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/signed_adder_arbiter.sv
// NUM_REQ requesters share one registered signed 4-bit adder through a round-robin arbiter.
// Define SIGNED_ADDER_ARB_OVF_EN to add the registered rsp_ovf output.
module signed_adder_arbiter
    import signed_adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][OPND_W-1:0] req_x,
    input  logic [NUM_REQ-1:0][OPND_W-1:0] req_y,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [SUM_W-1:0]               rsp_data,
    output logic [ID_W-1:0]                rsp_id
`ifdef SIGNED_ADDER_ARB_OVF_EN
    ,
    output logic                           rsp_ovf
`endif
);

    state_e             state_q;
    sum_t               data_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0] grant;
    logic               slot_free;
    logic               transfer;
    opnd_t              x_sel;
    opnd_t              y_sel;
    sum_t               sum_d;

    // The result slot can take a new sum when it is empty or being drained this cycle.
    assign slot_free = (state_q == ST_EMPTY) || rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .enable_i (slot_free),
        .grant_o  (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id = ID_W'(i);
            end
        end
    end

    // Single shared adder fed from the granted requester's operands.
    assign x_sel = opnd_t'(req_x[gnt_id]);
    assign y_sel = opnd_t'(req_y[gnt_id]);
    assign sum_d = add_sext(x_sel, y_sel);

    assign ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

`ifdef SIGNED_ADDER_ARB_OVF_EN
    logic ovf_q;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
`ifdef SIGNED_ADDER_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: if (transfer) state_q <= ST_FULL;
                ST_FULL:  if (rsp_ready && !transfer) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
            if (transfer) begin
                data_q <= sum_d;
                id_q   <= gnt_id;
                ptr_q  <= ptr_d;
`ifdef SIGNED_ADDER_ARB_OVF_EN
                ovf_q  <= sum_ovf(sum_d);
`endif
            end
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
`ifdef SIGNED_ADDER_ARB_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

    // Handshake invariants: at most one grant, and none while a held result is blocked.
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_no_grant_when_blocked : assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |-> (req_ready == '0));
    a_hold_when_blocked : assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule
